// File: rtl/ctrl_pipeline_pkg.sv
// Shared constants for the control-path pipeline:
// bundle bit positions, branch condition codes, pcsrc selects.
package ctrl_pipeline_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLEZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

endpackage

// File: rtl/ctrl_pipeline_branch_cmp.sv
// Branch condition evaluation on forwarded ID operands.
// Zero tests treat cmp_a as signed.
module branch_cmp
  import ctrl_pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  input  logic [2:0]        br_type,
  output logic              cond
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = cmp_a[DATA_W-1];
  assign a_zero = (cmp_a == '0);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = (cmp_a == cmp_b);
      BR_BNE:  cond = (cmp_a != cmp_b);
      BR_BLEZ: cond = a_neg | a_zero;
      BR_BGTZ: cond = ~a_neg & ~a_zero;
      BR_BLTZ: cond = a_neg;
      BR_BGEZ: cond = ~a_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-path pipeline: ID hazard stall, branch/jump resolution,
// and STAGES registered stages with hold, bubble and flush.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int STAGES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic [4:0]               id_dst,
  input  logic [4:0]               id_rs,
  input  logic [4:0]               id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic                     id_branch,
  input  logic                     id_jump,
  input  logic                     id_jr,
  input  logic [2:0]               id_br_type,
  input  logic [DATA_W-1:0]        cmp_a,
  input  logic [DATA_W-1:0]        cmp_b,
  input  logic [STAGES-1:0]        stall_in,
  input  logic [STAGES-1:0]        flush_in,
  output logic [STAGES*CTRL_W-1:0] ctrl_q,
  output logic [STAGES*5-1:0]      dst_q,
  output logic [STAGES-1:0]        valid_q,
  output logic                     id_stall,
  output logic                     br_taken,
  output logic [1:0]               pcsrc
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] q_valid;
  logic [CTRL_W-1:0] q_ctrl [STAGES];
  logic [4:0]        q_dst  [STAGES];
  logic [1:0]        match;
  logic              load_use;
  logic              br_haz;
  logic              cond;

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      hold[i] = |(stall_in >> i);
    end
  end

  // A stage only produces a hazard if it really writes a nonzero reg
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      match[i] = q_valid[i] && (q_dst[i] != 5'd0) &&
                 ((id_uses_rs && id_rs == q_dst[i]) ||
                  (id_uses_rt && id_rt == q_dst[i]));
    end
  end

  assign load_use = match[0] & q_ctrl[0][CTRL_MEMTOREG];
  assign br_haz   = (id_branch | id_jr) &
                    ((match[0] & q_ctrl[0][CTRL_REGWRITE]) |
                     (match[1] & q_ctrl[1][CTRL_MEMTOREG]));
  assign id_stall = (id_valid & (load_use | br_haz)) | (|stall_in);

  branch_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .cmp_a   (cmp_a),
    .cmp_b   (cmp_b),
    .br_type (id_br_type),
    .cond    (cond)
  );

  assign br_taken = id_valid & id_branch & cond & ~id_stall;

  always_comb begin
    pcsrc = PC_SEQ;
    if (id_valid && !id_stall) begin
      priority case (1'b1)
        id_jr:    pcsrc = PC_JR;
        id_jump:  pcsrc = PC_J;
        br_taken: pcsrc = PC_BR;
        default:  pcsrc = PC_SEQ;
      endcase
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      // A hazard-only stall turns into a bubble in EX
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_valid[g] <= 1'b0;
          q_ctrl[g]  <= '0;
          q_dst[g]   <= '0;
        end else if (flush_in[g]) begin
          q_valid[g] <= 1'b0;
          q_ctrl[g]  <= '0;
          q_dst[g]   <= '0;
        end else if (!hold[g]) begin
          if (id_stall || !id_valid) begin
            q_valid[g] <= 1'b0;
            q_ctrl[g]  <= '0;
            q_dst[g]   <= '0;
          end else begin
            q_valid[g] <= 1'b1;
            q_ctrl[g]  <= id_ctrl;
            q_dst[g]   <= id_dst;
          end
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_valid[g] <= 1'b0;
          q_ctrl[g]  <= '0;
          q_dst[g]   <= '0;
        end else if (flush_in[g]) begin
          q_valid[g] <= 1'b0;
          q_ctrl[g]  <= '0;
          q_dst[g]   <= '0;
        end else if (!hold[g]) begin
          if (hold[g-1]) begin
            q_valid[g] <= 1'b0;
            q_ctrl[g]  <= '0;
            q_dst[g]   <= '0;
          end else begin
            q_valid[g] <= q_valid[g-1];
            q_ctrl[g]  <= q_ctrl[g-1];
            q_dst[g]   <= q_dst[g-1];
          end
        end
      end
    end

    assign ctrl_q[g*CTRL_W +: CTRL_W] = q_ctrl[g];
    assign dst_q[g*5 +: 5]            = q_dst[g];
    assign valid_q[g]                 = q_valid[g];
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: branch-decision table plus
// hand-written hazard, stall, flush and reset sequences.
module tb_ctrl_pipeline;
  import ctrl_pipeline_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NS = 3;

  localparam logic [CW-1:0] C_ALU  = 16'h0001;
  localparam logic [CW-1:0] C_LOAD = 16'h0003;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [CW-1:0] id_ctrl;
  logic [4:0]    id_dst, id_rs, id_rt;
  logic          id_uses_rs, id_uses_rt;
  logic          id_branch, id_jump, id_jr;
  logic [2:0]    id_br_type;
  logic [DW-1:0] cmp_a, cmp_b;
  logic [NS-1:0] stall_in, flush_in;
  logic [NS*CW-1:0] ctrl_q;
  logic [NS*5-1:0]  dst_q;
  logic [NS-1:0]    valid_q;
  logic          id_stall, br_taken;
  logic [1:0]    pcsrc;

  int tests = 0;
  int fails = 0;

  ctrl_pipeline #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .STAGES (NS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_ctrl    (id_ctrl),
    .id_dst     (id_dst),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_branch  (id_branch),
    .id_jump    (id_jump),
    .id_jr      (id_jr),
    .id_br_type (id_br_type),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .ctrl_q     (ctrl_q),
    .dst_q      (dst_q),
    .valid_q    (valid_q),
    .id_stall   (id_stall),
    .br_taken   (br_taken),
    .pcsrc      (pcsrc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          br;
    logic          j;
    logic          jr;
    logic [2:0]    bt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          exp_t;
    logic [1:0]    exp_pc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [CW-1:0] c,
                        input logic [4:0] d, input logic [4:0] rs,
                        input logic urs, input logic br,
                        input logic jr, input logic [2:0] bt);
    id_valid   = v;
    id_ctrl    = c;
    id_dst     = d;
    id_rs      = rs;
    id_rt      = 5'd0;
    id_uses_rs = urs;
    id_uses_rt = 1'b0;
    id_branch  = br;
    id_jump    = 1'b0;
    id_jr      = jr;
    id_br_type = bt;
  endtask

  task automatic drain();
    set_id(1'b0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (4) tick();
  endtask

  initial begin
    vecs[0]  = '{1, 1, 0, 0, BR_BEQ,  32'd5, 32'd5, 1, PC_BR};
    vecs[1]  = '{1, 1, 0, 0, BR_BNE,  32'd5, 32'd5, 0, PC_SEQ};
    vecs[2]  = '{1, 1, 0, 0, BR_BLTZ, 32'h8000_0000, 32'd0, 1, PC_BR};
    vecs[3]  = '{1, 1, 0, 0, BR_BLEZ, 32'd1, 32'd0, 0, PC_SEQ};
    vecs[4]  = '{1, 1, 0, 0, 3'd7,    32'd5, 32'd5, 0, PC_SEQ};
    vecs[5]  = '{1, 1, 0, 0, BR_BLEZ, 32'd0, 32'd9, 1, PC_BR};
    vecs[6]  = '{1, 1, 0, 0, BR_BGTZ, 32'd0, 32'd0, 0, PC_SEQ};
    vecs[7]  = '{1, 1, 0, 0, BR_BGEZ, 32'hffff_ffff, 32'd0, 0, PC_SEQ};
    vecs[8]  = '{1, 1, 0, 0, BR_BGEZ, 32'd0, 32'd0, 1, PC_BR};
    vecs[9]  = '{1, 1, 0, 0, BR_BNE,  32'd3, 32'd4, 1, PC_BR};
    vecs[10] = '{1, 0, 1, 0, BR_BEQ,  32'd1, 32'd2, 0, PC_J};
    vecs[11] = '{1, 0, 0, 1, BR_BEQ,  32'd1, 32'd2, 0, PC_JR};
    vecs[12] = '{1, 1, 0, 1, BR_BEQ,  32'd7, 32'd7, 1, PC_JR};
    vecs[13] = '{0, 1, 0, 0, BR_BEQ,  32'd5, 32'd5, 0, PC_SEQ};

    rst = 1'b1;
    stall_in = '0;
    flush_in = '0;
    cmp_a = '0;
    cmp_b = '0;
    set_id(1'b0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #12;
    chk("reset_valid", 64'(valid_q), 64'd0);
    chk("reset_ctrl", 64'(ctrl_q), 64'd0);
    chk("reset_dst", 64'(dst_q), 64'd0);
    chk("reset_pcsrc", 64'(pcsrc), 64'(PC_SEQ));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      set_id(vecs[i].v, '0, 5'd0, 5'd0, 1'b0, vecs[i].br,
             vecs[i].jr, vecs[i].bt);
      id_jump = vecs[i].j;
      cmp_a = vecs[i].a;
      cmp_b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_taken", i), 64'(br_taken), 64'(vecs[i].exp_t));
      chk($sformatf("vec%0d_pcsrc", i), 64'(pcsrc), 64'(vecs[i].exp_pc));
    end
    drain();

    // load-use
    set_id(1'b1, C_LOAD, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    set_id(1'b1, C_ALU, 5'd11, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    chk("lu_stall", 64'(id_stall), 64'd1);
    tick();
    chk("lu_bubble", 64'(valid_q[0]), 64'd0);
    chk("lu_ld_s1_dst", 64'(dst_q[9:5]), 64'd8);
    chk("lu_ld_s1_valid", 64'(valid_q[1]), 64'd1);
    chk("lu_stall_gone", 64'(id_stall), 64'd0);
    tick();
    chk("lu_add_valid", 64'(valid_q[0]), 64'd1);
    chk("lu_add_dst", 64'(dst_q[4:0]), 64'd11);
    chk("lu_add_ctrl", 64'(ctrl_q[CW-1:0]), 64'(C_ALU));
    drain();

    // jr behind ALU producer
    set_id(1'b1, C_ALU, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    set_id(1'b1, '0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 3'd0);
    #1;
    chk("jr_stall", 64'(id_stall), 64'd1);
    chk("jr_pcsrc_held", 64'(pcsrc), 64'(PC_SEQ));
    tick();
    chk("jr_stall_clear", 64'(id_stall), 64'd0);
    chk("jr_pcsrc", 64'(pcsrc), 64'(PC_JR));
    drain();

    // r0 producer never stalls
    set_id(1'b1, C_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    set_id(1'b1, '0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, BR_BEQ);
    cmp_a = 32'd1;
    cmp_b = 32'd1;
    #1;
    chk("r0_no_stall", 64'(id_stall), 64'd0);
    drain();

    // branch behind load: two stall cycles
    set_id(1'b1, C_LOAD, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    set_id(1'b1, '0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0, BR_BEQ);
    cmp_a = 32'd4;
    cmp_b = 32'd4;
    #1;
    chk("brld_stall1", 64'(id_stall), 64'd1);
    chk("brld_taken1", 64'(br_taken), 64'd0);
    tick();
    chk("brld_stall2", 64'(id_stall), 64'd1);
    tick();
    chk("brld_stall3", 64'(id_stall), 64'd0);
    chk("brld_taken", 64'(br_taken), 64'd1);
    chk("brld_pcsrc", 64'(pcsrc), 64'(PC_BR));
    drain();

    // external stall on MEM
    for (int k = 1; k <= 3; k++) begin
      set_id(1'b1, C_ALU, 5'(k), 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
    end
    set_id(1'b1, C_ALU, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    stall_in = 3'b010;
    #1;
    chk("xs_id_stall", 64'(id_stall), 64'd1);
    tick();
    stall_in = '0;
    chk("xs_valid", 64'(valid_q), 64'b011);
    chk("xs_dst", 64'(dst_q), 64'({5'd0, 5'd2, 5'd3}));

    // flush wins over stall in EX
    stall_in = 3'b001;
    flush_in = 3'b001;
    tick();
    stall_in = '0;
    flush_in = '0;
    chk("fl_s0", 64'(valid_q[0]), 64'd0);
    chk("fl_s1_bubble", 64'(valid_q[1]), 64'd0);
    drain();

    // async reset with full pipe
    for (int k = 5; k <= 7; k++) begin
      set_id(1'b1, C_LOAD, 5'(k), 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
    end
    chk("full_before_rst", 64'(valid_q), 64'b111);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_q), 64'd0);
    chk("arst_ctrl", 64'(ctrl_q), 64'd0);
    chk("arst_dst", 64'(dst_q), 64'd0);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
